// File: rtl/freq_bcd_if.sv
// Request/result bundle between the frequency source and the BCD formatter.
// The master drives a request; the slave returns display digits and status.
interface freq_bcd_if;
   logic        start;
   logic [19:0] freq_in;
   logic [3:0]  hex0;
   logic [3:0]  hex1;
   logic [3:0]  hex2;
   logic [3:0]  hex3;
   logic [3:0]  dp_out;
   logic        busy;
   logic        done;
   logic        ovf;

   modport master (
      output start,
      output freq_in,
      input  hex0,
      input  hex1,
      input  hex2,
      input  hex3,
      input  dp_out,
      input  busy,
      input  done,
      input  ovf
   );

   modport slave (
      input  start,
      input  freq_in,
      output hex0,
      output hex1,
      output hex2,
      output hex3,
      output dp_out,
      output busy,
      output done,
      output ovf
   );
endinterface

// File: rtl/freq_bcd_formatter.sv
// 20-bit Hz value to four auto-ranged BCD digits with decimal points,
// using a sequential double-dabble converter.
module freq_bcd_formatter #(
   parameter logic [3:0] ERR_DIGIT   = 4'hE,
   parameter int         CONV_CYCLES = 20
) (
   input logic       clk,
   input logic       rst_n,
   freq_bcd_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FORMAT
   } state_t;

   localparam logic [19:0] MAX_IN_RANGE = 20'd999999;
   localparam logic [4:0]  LAST_ITER    = 5'(CONV_CYCLES - 1);

   state_t      state_q;
   state_t      state_d;

   logic [19:0] bin_q;
   logic [23:0] bcd_q;
   logic [4:0]  cnt_q;
   logic        big_q;

   logic [23:0] bcd_adj;
   logic [15:0] fmt_hex;
   logic [3:0]  fmt_dp;
   logic        last_iter;

   logic [15:0] hex_q;
   logic [3:0]  dp_q;
   logic        ovf_q;
   logic        done_q;

   assign last_iter = (cnt_q == LAST_ITER);

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 6; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Range comes from the BCD digits; the error case from the raw input,
   // since values above 999999 wrap the six-digit accumulator.
   always_comb begin
      fmt_hex = bcd_q[15:0];
      fmt_dp  = 4'b0000;
      if (big_q) begin
         fmt_hex = {4{ERR_DIGIT}};
         fmt_dp  = 4'b0000;
      end else if (bcd_q[23:20] != 4'd0) begin
         fmt_hex = bcd_q[23:8];
         fmt_dp  = 4'b0010;
      end else if (bcd_q[19:16] != 4'd0) begin
         fmt_hex = bcd_q[19:4];
         fmt_dp  = 4'b0100;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (last_iter) begin
               state_d = FORMAT;
            end
         end
         FORMAT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         big_q  <= 1'b0;
         hex_q  <= '0;
         dp_q   <= '0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  bin_q <= bus.freq_in;
                  bcd_q <= '0;
                  cnt_q <= '0;
                  big_q <= (bus.freq_in > MAX_IN_RANGE);
               end
            end
            SHIFT: begin
               {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
               cnt_q          <= cnt_q + 5'd1;
            end
            FORMAT: begin
               hex_q  <= fmt_hex;
               dp_q   <= fmt_dp;
               ovf_q  <= big_q;
               done_q <= 1'b1;
            end
            default: begin
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hex0   = hex_q[3:0];
   assign bus.hex1   = hex_q[7:4];
   assign bus.hex2   = hex_q[11:8];
   assign bus.hex3   = hex_q[15:12];
   assign bus.dp_out = dp_q;
   assign bus.ovf    = ovf_q;
   assign bus.done   = done_q;
   assign bus.busy   = (state_q != IDLE);

endmodule

// File: doc/freq_bcd_formatter.md
Name: freq_bcd_formatter

Overview:
Converts a 20-bit binary frequency value in Hz into four BCD digits plus decimal-point enables for the 4-digit seven-segment display driver in the DDS path. Conversion is sequential double-dabble (shift-add-3). The block then auto-ranges to Hz or kHz, placing the decimal point so four significant digits are shown. It sits directly upstream of the display driver. Its outputs map one-to-one onto that driver's hex0..hex3 and dp_in inputs. hex0 is the rightmost (least significant) digit.

Parameters:
ERR_DIGIT, 4'hE, nibble driven on all four digits when the input is out of range.
CONV_CYCLES, 20, number of shift iterations. Equals the input width and is fixed. It is exposed only for bench reference.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; samples freq_in when the block is idle
freq_in  input  20  unsigned frequency in Hz
hex0  output  4  BCD digit, rightmost
hex1  output  4  BCD digit
hex2  output  4  BCD digit
hex3  output  4  BCD digit, leftmost
dp_out  output  4  decimal-point enables; bit i lights the dp of digit i
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when the outputs have been updated
ovf  output  1  high when the last converted value exceeded 999999

Behaviour:
- Reset is asynchronous active-low and applies in any state. On reset:
  - hex0..hex3 = 0 and dp_out = 4'b0000.
  - busy = 0, done = 0, ovf = 0.
  - The FSM returns to IDLE and the internal shift and BCD registers are cleared.
  - Asserting reset mid-conversion aborts the conversion. The outputs show the reset values and no done pulse is issued.
- FSM states: IDLE, SHIFT, FORMAT, IDLE.
- IDLE, when start = 1 at clock edge k:
  - Capture freq_in into the shift register and clear the 24-bit BCD accumulator (six digits).
  - Load the iteration counter with 0 and go to SHIFT.
  - busy goes high from edge k.
- SHIFT: each cycle, for every BCD nibble of 5 or more, add 3, then shift {bcd, bin} left by one bit.
  - After 20 iterations (edges k+1..k+20), go to FORMAT.
  - The add and the shift use the post-add values within the same cycle.
- FORMAT, at edge k+21: register the outputs. Let b5..b0 be the BCD digits, with b5 the most significant.
  - value <= 9999: hex3..hex0 = b3,b2,b1,b0 and dp_out = 4'b0000. Display is in Hz.
  - 10000 to 99999: hex3..hex0 = b4,b3,b2,b1 and dp_out = 4'b0100. Display is XX.XX kHz.
  - 100000 to 999999: hex3..hex0 = b5,b4,b3,b2 and dp_out = 4'b0010. Display is XXX.X kHz.
  - Greater than 999999 (up to 1048575): all digits = ERR_DIGIT, dp_out = 4'b0000, ovf = 1. For any in-range value, ovf = 0.
  - Range is decided from the BCD result: b5 != 0, else b4 != 0, else Hz.
  - Overflow is decided from the captured binary value compared against 999999.
  - Truncate, never round. Leading zeros are displayed, not blanked.
- Also at edge k+21: done = 1 for exactly one cycle, busy = 0, and the FSM returns to IDLE.
  - Total latency is 21 edges from the start sample to valid outputs and done.
  - A new start is accepted from edge k+22 onward.
- Outputs hold their previous values throughout a conversion. They update atomically at FORMAT, so the display never shows partial results.
- start while busy = 1 is ignored: not queued, no effect on the running conversion. freq_in changes after capture have no effect.
- A start asserted in the same cycle that done is high is sampled normally, because the FSM is already in IDLE at that edge.

Test Plan:
- Reset, then start with freq_in = 1234 -> done exactly 21 edges after the start sample; hex3..0 = 1,2,3,4; dp_out = 0000; ovf = 0; busy high for 21 cycles.
- freq_in = 12345 -> hex3..0 = 1,2,3,4; dp_out = 0100. Then 654321 -> hex3..0 = 6,5,4,3; dp_out = 0010.
- Boundaries, each checked against the range rules:
  - 0 -> 0,0,0,0 / 0000.
  - 9999 -> 9,9,9,9 / 0000.
  - 10000 -> 1,0,0,0 / 0100.
  - 999999 -> 9,9,9,9 / 0010, ovf = 0.
- 1000000 and 1048575 -> hex all E, dp_out = 0000, ovf = 1. Following conversion of 5 -> ovf clears and digits show 0,0,0,5.
- Start 1234; pulse start with 9876 at busy cycle 5, with freq_in also changed -> result is still 1,2,3,4 and exactly one done pulse.
- Start 4321 after a completed 1234; assert rst_n low at busy cycle 10 -> outputs immediately 0 / 0000, busy = 0, no done pulse. After release, start 77 -> 0,0,7,7.
